// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master controller, its bus
// interface and the transmit shifter.
//   spi_state_e      - controller FSM state encoding
//   SPI_FRAME_BITS   - bits per SPI frame
//   SPI_CLK_DIV_DEF  - default SCLK half-period in clk cycles
//   SPI_CS_GAP_DEF   - default minimum cs_n-high time between frames
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEAD,
        ST_SCLK_H,
        ST_SCLK_L,
        ST_TRAIL,
        ST_GAP
    } spi_state_e;

    localparam int unsigned SPI_FRAME_BITS  = 32;
    localparam int unsigned SPI_CLK_DIV_DEF = 4;
    localparam int unsigned SPI_CS_GAP_DEF  = 2;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: handshake and SPI bus signals of spi_master_ctrl.
//   start           - frame request (to controller)
//   busy / done     - frame in progress / end-of-frame pulse (from controller)
//   rx_data         - last received frame
//   tx_shifter_load - load strobe for the transmit shifter
//   tx_shift_en     - shift strobe for the transmit shifter
//   spi_sclk        - SPI clock, mode 0
//   spi_cs_n        - active-low chip select
//   spi_miso        - serial data in (to controller)
// modport master: the controller side; modport slave: the surrounding logic.
interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic                      start;
    logic                      busy;
    logic                      done;
    logic [SPI_FRAME_BITS-1:0] rx_data;
    logic                      tx_shifter_load;
    logic                      tx_shift_en;
    logic                      spi_sclk;
    logic                      spi_cs_n;
    logic                      spi_miso;

    modport master (
        input  start, spi_miso,
        output busy, done, rx_data, tx_shifter_load, tx_shift_en,
               spi_sclk, spi_cs_n
    );

    modport slave (
        output start, spi_miso,
        input  busy, done, rx_data, tx_shifter_load, tx_shift_en,
               spi_sclk, spi_cs_n
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: MSB-first transmit shifter driven by spi_master_ctrl.
//   clk, reset  - clock, asynchronous active-high reset
//   load_i      - capture tx_data_i into the shift register
//   shift_en_i  - present the next bit (MSB first) on mosi_o
//   tx_data_i   - frame to transmit
//   mosi_o      - serial data out (registered)
module spi_tx_shifter
    import spi_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic                      shift_en_i,
    input  logic [SPI_FRAME_BITS-1:0] tx_data_i,
    output logic                      mosi_o
);

    logic [SPI_FRAME_BITS-1:0] sr_q;
    logic                      mosi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q   <= '0;
            mosi_q <= 1'b0;
        end else if (load_i) begin
            sr_q   <= tx_data_i;
        end else if (shift_en_i) begin
            mosi_q <= sr_q[SPI_FRAME_BITS-1];
            sr_q   <= {sr_q[SPI_FRAME_BITS-2:0], 1'b0};
        end
    end

    assign mosi_o = mosi_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master frame controller (32-bit frames).
//   clk, reset - clock, asynchronous active-high reset
//   bus        - spi_master_ctrl_if.master: start/busy/done handshake,
//                rx_data, transmit shifter strobes and the SPI pins.
// The transmit shifter lives beside this block and is driven by
// tx_shifter_load / tx_shift_en.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int unsigned CS_GAP  = SPI_CS_GAP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_ctrl_if.master   bus
);

    localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD  = 8'(CS_GAP - 1);
    localparam logic [5:0] LAST_BIT    = 6'(SPI_FRAME_BITS);

    spi_state_e                state_q, state_d;
    logic [7:0]                hcnt_q, hcnt_d;
    logic [5:0]                bitcnt_q, bitcnt_d;
    logic                      entry_d, entry_q;
    logic                      done_d;
    logic [SPI_FRAME_BITS-1:0] rx_sr_q, rx_data_q;
    logic                      busy_q, done_q, load_q, shift_q, sclk_q, cs_n_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.start)      state_d = ST_LOAD;
            ST_LOAD:                       state_d = ST_LEAD;
            ST_LEAD:   if (hcnt_q == '0)   state_d = ST_SCLK_H;
            ST_SCLK_H: if (hcnt_q == '0)   state_d = (bitcnt_q == LAST_BIT) ? ST_TRAIL : ST_SCLK_L;
            ST_SCLK_L: if (hcnt_q == '0)   state_d = ST_SCLK_H;
            ST_TRAIL:  if (hcnt_q == '0)   state_d = ST_GAP;
            ST_GAP:    if (hcnt_q == '0)   state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase

        entry_d = (state_d != state_q);

        hcnt_d = hcnt_q;
        if (entry_d) begin
            unique case (state_d)
                ST_IDLE: hcnt_d = '0;
                ST_GAP:  hcnt_d = GAP_RELOAD;
                default: hcnt_d = HALF_RELOAD;
            endcase
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - 8'd1;
        end

        // Counts SCLK_H entries; reaching LAST_BIT diverts SCLK_H to TRAIL.
        bitcnt_d = bitcnt_q;
        if (entry_d && state_d == ST_LOAD) begin
            bitcnt_d = '0;
        end else if (entry_d && state_d == ST_SCLK_H) begin
            bitcnt_d = bitcnt_q + 6'd1;
        end

        done_d = (state_d == ST_GAP) && (hcnt_d == '0);
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            bitcnt_q  <= '0;
            entry_q   <= 1'b0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bitcnt_q <= bitcnt_d;
            entry_q  <= entry_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= done_d;
            load_q   <= (state_d == ST_LOAD);
            shift_q  <= entry_d && (state_d == ST_LEAD || state_d == ST_SCLK_L);
            sclk_q   <= (state_d == ST_SCLK_H);
            cs_n_q   <= !(state_d inside {ST_LOAD, ST_LEAD, ST_SCLK_H, ST_SCLK_L, ST_TRAIL});
            // MISO is captured at the end of the first SCLK-high cycle.
            if (state_q == ST_SCLK_H && entry_q) begin
                rx_sr_q <= {rx_sr_q[SPI_FRAME_BITS-2:0], bus.spi_miso};
            end
            if (done_d) begin
                rx_data_q <= rx_sr_q;
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.rx_data         = rx_data_q;
    assign bus.tx_shifter_load = load_q;
    assign bus.tx_shift_en     = shift_q;
    assign bus.spi_sclk        = sclk_q;
    assign bus.spi_cs_n        = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl.
// dut_a: CLK_DIV=2, CS_GAP=2 with MOSI looped back to MISO.
// dut_b: CLK_DIV=1, CS_GAP=3 with MISO tied high.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_ctrl_if ifa ();
    spi_master_ctrl_if ifb ();

    logic [31:0] tx_a, tx_b;
    logic        mosi_a, mosi_b;

    spi_master_ctrl #(.CLK_DIV(2), .CS_GAP(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
    spi_master_ctrl #(.CLK_DIV(1), .CS_GAP(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

    spi_tx_shifter sh_a (.clk(clk), .reset(reset), .load_i(ifa.tx_shifter_load),
                         .shift_en_i(ifa.tx_shift_en), .tx_data_i(tx_a), .mosi_o(mosi_a));
    spi_tx_shifter sh_b (.clk(clk), .reset(reset), .load_i(ifb.tx_shifter_load),
                         .shift_en_i(ifb.tx_shift_en), .tx_data_i(tx_b), .mosi_o(mosi_b));

    assign ifa.spi_miso = mosi_a;
    assign ifb.spi_miso = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Event monitor for dut_a, sampled on the falling edge.
    int unsigned m_shift = 0, m_load = 0, m_coinc = 0, m_rise = 0, m_csbad = 0, m_done = 0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;
    logic [31:0] mosi_cap = '0;

    always @(negedge clk) begin
        if (ifa.tx_shift_en === 1'b1) m_shift++;
        if (ifa.tx_shifter_load === 1'b1) m_load++;
        if (ifa.tx_shift_en === 1'b1 && ifa.tx_shifter_load === 1'b1) m_coinc++;
        if (ifa.spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
            m_rise++;
            mosi_cap = {mosi_cap[30:0], mosi_a};
        end
        if (ifa.spi_cs_n !== prev_cs && ifa.spi_sclk !== 1'b0) m_csbad++;
        if (ifa.done === 1'b1) m_done++;
        prev_sclk = ifa.spi_sclk;
        prev_cs   = ifa.spi_cs_n;
    end

    task automatic test_reset();
        reset = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        tx_a = '0;
        tx_b = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
        n_checks++; if (ifa.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ifa.done); end
        n_checks++; if (ifa.tx_shifter_load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", ifa.tx_shifter_load); end
        n_checks++; if (ifa.tx_shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_shift: got %b want 0", ifa.tx_shift_en); end
        n_checks++; if (ifa.spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", ifa.spi_sclk); end
        n_checks++; if (ifa.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", ifa.spi_cs_n); end
        n_checks++; if (ifa.rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0", ifa.rx_data); end
        n_checks++; if (ifb.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_b_cs_n: got %b want 1", ifb.spi_cs_n); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Single frame with loopback: timing, pulse counts and data.
    task automatic test_frame();
        int unsigned b_shift, b_load, b_coinc, b_rise, b_csbad, b_done;
        int busy_cycles, first_rise;
        #1;
        b_shift = m_shift; b_load = m_load; b_coinc = m_coinc;
        b_rise = m_rise; b_csbad = m_csbad; b_done = m_done;
        tx_a = 32'hA5C3_0F96;
        @(negedge clk); ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        n_checks++; if (ifa.spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL frame_cs_fall: got %b want 0", ifa.spi_cs_n); end
        n_checks++; if (ifa.tx_shifter_load !== 1'b1) begin n_fail++; $display("FAIL frame_load: got %b want 1", ifa.tx_shifter_load); end
        busy_cycles = 0;
        first_rise  = -1;
        for (int i = 0; i < 1000 && ifa.busy === 1'b1; i++) begin
            if (ifa.spi_sclk === 1'b1 && first_rise < 0) first_rise = i;
            busy_cycles++;
            @(negedge clk);
        end
        @(negedge clk); #1;
        n_checks++; if (busy_cycles != 133) begin n_fail++; $display("FAIL frame_busy_len: got %0d want 133", busy_cycles); end
        n_checks++; if (first_rise != 3) begin n_fail++; $display("FAIL frame_first_rise: got %0d want 3", first_rise); end
        n_checks++; if (m_done - b_done != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", m_done - b_done); end
        n_checks++; if (ifa.rx_data !== 32'hA5C3_0F96) begin n_fail++; $display("FAIL loop_rx_data: got %h want a5c30f96", ifa.rx_data); end
        n_checks++; if (mosi_cap !== 32'hA5C3_0F96) begin n_fail++; $display("FAIL loop_mosi_bits: got %h want a5c30f96", mosi_cap); end
        n_checks++; if (m_shift - b_shift != 32) begin n_fail++; $display("FAIL pulse_shift_count: got %0d want 32", m_shift - b_shift); end
        n_checks++; if (m_load - b_load != 1) begin n_fail++; $display("FAIL pulse_load_count: got %0d want 1", m_load - b_load); end
        n_checks++; if (m_coinc != b_coinc) begin n_fail++; $display("FAIL pulse_coincident: got %0d want 0", m_coinc - b_coinc); end
        n_checks++; if (m_rise - b_rise != 32) begin n_fail++; $display("FAIL pulse_sclk_rises: got %0d want 32", m_rise - b_rise); end
        n_checks++; if (m_csbad != b_csbad) begin n_fail++; $display("FAIL cs_edge_sclk_high: got %0d want 0", m_csbad - b_csbad); end
    endtask

    // A start pulse inside a frame must neither restart nor queue a frame.
    task automatic test_ignored_start();
        int unsigned b_done;
        int busy_late;
        #1;
        b_done = m_done;
        tx_a = 32'h1234_5678;
        @(negedge clk); ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        repeat (20) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        for (int i = 0; i < 1000 && ifa.busy === 1'b1; i++) @(negedge clk);
        busy_late = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (ifa.busy !== 1'b0) busy_late++;
        end
        #1;
        n_checks++; if (m_done - b_done != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", m_done - b_done); end
        n_checks++; if (busy_late != 0) begin n_fail++; $display("FAIL ignored_extra_frame: got %0d busy cycles want 0", busy_late); end
        n_checks++; if (ifa.rx_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ignored_rx_data: got %h want 12345678", ifa.rx_data); end
    endtask

    // start held high: three frames, cs_n high for CS_GAP+1 cycles between them.
    task automatic test_back_to_back();
        int unsigned b_done;
        int dcount, run, ngaps, gap0, gap1;
        logic prev, seen_fall;
        #1;
        b_done = m_done;
        tx_a = 32'h0F0F_3C3C;
        dcount = 0; run = 0; ngaps = 0; gap0 = -1; gap1 = -1;
        prev = 1'b1; seen_fall = 1'b0;
        @(negedge clk); ifa.start = 1'b1;
        for (int i = 0; i < 2000 && dcount < 3; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && ifa.spi_cs_n === 1'b0) begin
                if (seen_fall) begin
                    if (ngaps == 0) gap0 = run; else gap1 = run;
                    ngaps++;
                end
                seen_fall = 1'b1;
            end
            if (ifa.spi_cs_n === 1'b1) run++; else run = 0;
            prev = ifa.spi_cs_n;
            if (ifa.done === 1'b1) dcount++;
        end
        ifa.start = 1'b0;
        for (int i = 0; i < 100; i++) @(negedge clk);
        #1;
        n_checks++; if (m_done - b_done != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", m_done - b_done); end
        n_checks++; if (ngaps != 2) begin n_fail++; $display("FAIL b2b_gap_count: got %0d want 2", ngaps); end
        n_checks++; if (gap0 != 3) begin n_fail++; $display("FAIL b2b_gap0_len: got %0d want 3", gap0); end
        n_checks++; if (gap1 != 3) begin n_fail++; $display("FAIL b2b_gap1_len: got %0d want 3", gap1); end
        n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b want 0", ifa.busy); end
        n_checks++; if (ifa.rx_data !== 32'h0F0F_3C3C) begin n_fail++; $display("FAIL b2b_rx_data: got %h want 0f0f3c3c", ifa.rx_data); end
    endtask

    // Reset at bit 10 aborts asynchronously; the next frame completes normally.
    task automatic test_abort();
        int unsigned b_done, b_rise;
        int waited;
        #1;
        b_done = m_done;
        b_rise = m_rise;
        tx_a = 32'hDEAD_BEEF;
        @(negedge clk); ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        waited = 0;
        while (m_rise - b_rise < 10 && waited < 1000) begin
            @(negedge clk); #1;
            waited++;
        end
        n_checks++; if (m_rise - b_rise != 10) begin n_fail++; $display("FAIL abort_reach_bit10: got %0d rises want 10", m_rise - b_rise); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", ifa.busy); end
        n_checks++; if (ifa.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL abort_cs_n: got %b want 1", ifa.spi_cs_n); end
        n_checks++; if (ifa.spi_sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b want 0", ifa.spi_sclk); end
        n_checks++; if (ifa.tx_shift_en !== 1'b0) begin n_fail++; $display("FAIL abort_shift: got %b want 0", ifa.tx_shift_en); end
        n_checks++; if (ifa.rx_data !== 32'h0) begin n_fail++; $display("FAIL abort_rx_data: got %h want 0", ifa.rx_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (m_done != b_done) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", m_done - b_done); end
        tx_a = 32'h8000_0001;
        @(negedge clk); ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        for (int i = 0; i < 1000 && ifa.busy === 1'b1; i++) @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (m_done - b_done != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d want 1", m_done - b_done); end
        n_checks++; if (ifa.rx_data !== 32'h8000_0001) begin n_fail++; $display("FAIL abort_restart_rx: got %h want 80000001", ifa.rx_data); end
    endtask

    // CLK_DIV=1: SCLK period of 2 cycles, MISO high gives all ones.
    task automatic test_min_div();
        int busy_cycles, rises, bad_period, last_rise, dones;
        logic prev;
        tx_b = 32'h5A5A_5A5A;
        @(negedge clk); ifb.start = 1'b1;
        @(negedge clk); ifb.start = 1'b0;
        busy_cycles = 0; rises = 0; bad_period = 0; last_rise = -1; dones = 0;
        prev = 1'b0;
        for (int i = 0; i < 1000 && ifb.busy === 1'b1; i++) begin
            if (ifb.spi_sclk === 1'b1 && prev === 1'b0) begin
                if (last_rise >= 0 && i - last_rise != 2) bad_period++;
                last_rise = i;
                rises++;
            end
            if (ifb.done === 1'b1) dones++;
            prev = ifb.spi_sclk;
            busy_cycles++;
            @(negedge clk);
        end
        n_checks++; if (busy_cycles != 69) begin n_fail++; $display("FAIL mindiv_busy_len: got %0d want 69", busy_cycles); end
        n_checks++; if (rises != 32) begin n_fail++; $display("FAIL mindiv_rises: got %0d want 32", rises); end
        n_checks++; if (bad_period != 0) begin n_fail++; $display("FAIL mindiv_sclk_period: got %0d bad periods want 0", bad_period); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL mindiv_done_count: got %0d want 1", dones); end
        n_checks++; if (ifb.rx_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mindiv_rx_data: got %h want ffffffff", ifb.rx_data); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ignored_start();
        test_back_to_back();
        test_abort();
        test_min_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
